isqrt_iter_fsm: RTL and testbench

//  Iterative integer square root unit: y = floor(sqrt(x)), one result digit per cycle.

---
 rtl/isqrt_iter_fsm.sv | 85 ++++++++
 tb/tb_isqrt_iter_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_iter_fsm.sv
// Iterative integer square root: y = floor(sqrt(x)), one result bit per cycle
// using the restoring digit-by-digit method. No ready; free again in the y_vld cycle.
module isqrt_iter_fsm #(
  parameter int n_bits = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                x_vld,
  input  logic [n_bits-1:0]   x,
  output logic                y_vld,
  output logic [n_bits/2-1:0] y,
  output logic                busy
);

  localparam int hw = n_bits / 2;
  localparam int cw = (hw > 1) ? $clog2(hw) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [n_bits-1:0] xs;
  logic [hw+1:0]     rem;
  logic [hw-1:0]     root;
  logic [cw-1:0]     cnt;

  logic              accept;
  logic [hw+3:0]     rem_sh;
  logic [hw+1:0]     trial;
  logic              ge;
  logic [hw+1:0]     rem_nxt;
  logic [hw-1:0]     root_nxt;

  // NOTE: combinational logic uses blocking '=' and assigns every output
  // unconditionally, so no latch can be inferred.
  always_comb begin
    accept   = x_vld && !rst && (state == ST_IDLE || state == ST_DONE);
    rem_sh   = {rem, xs[n_bits-1 -: 2]};
    trial    = {root, 2'b01};
    ge       = (rem_sh >= {2'b00, trial});
    // The true remainder after a successful subtract fits hw+2 bits.
    rem_nxt  = ge ? (rem_sh[hw+1:0] - trial) : rem_sh[hw+1:0];
    root_nxt = {root[hw-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      y     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (x_vld) state <= ST_BUSY;
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            y     <= root_nxt;
          end
        end
        ST_DONE: state <= x_vld ? ST_BUSY : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the iteration registers are fully reloaded on every capture and are
  // only observed in ST_BUSY, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      xs   <= x;
      rem  <= '0;
      root <= '0;
      cnt  <= cw'(hw - 1);
    end else if (state == ST_BUSY) begin
      xs   <= {xs[n_bits-3:0], 2'b00};
      rem  <= rem_nxt;
      root <= root_nxt;
      cnt  <= cnt - cw'(1);
    end
  end

  assign y_vld = (state == ST_DONE);
  assign busy  = (state == ST_BUSY);

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Self-checking bench for isqrt_iter_fsm (n_bits=32): directed vector table,
// hand-written corner sequences and a random run against a bit-search model.
module tb_isqrt_iter_fsm;

  localparam int N   = 32;
  localparam int LAT = 16;

  typedef struct {
    logic [31:0] x;
    logic [15:0] y;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_vld = 1'b0;
  logic [31:0] x = '0;
  logic        y_vld;
  logic [15:0] y;
  logic        busy;

  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  isqrt_iter_fsm #(.n_bits(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (y_vld) strobes <= strobes + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Largest r with r*r <= v, found by setting bits from the top.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'(1) << b);
      if (longint'(t) * longint'(t) <= longint'(v)) r = t;
    end
    return r;
  endfunction

  // Call at a negedge: drives the operand, lets it be taken, drops x_vld.
  task automatic start_now(input logic [31:0] v);
    x_vld = 1'b1;
    x     = v;
    @(posedge clk);
    @(negedge clk);
    x_vld = 1'b0;
  endtask

  task automatic start(input logic [31:0] v);
    @(negedge clk);
    start_now(v);
  endtask

  // Counts edges after the accepting edge until y_vld is seen (lat=-1 on
  // timeout). Optionally pulses x_vld with a junk operand at step pulse_at.
  task automatic wait_vld(input int pulse_at, input logic [31:0] junk, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (y_vld) begin
        lat = k;
        break;
      end
      if (k == pulse_at) begin
        x_vld = 1'b1;
        x     = junk;
      end else begin
        x_vld = 1'b0;
      end
    end
  endtask

  task automatic run_one(input string name, input logic [31:0] v, input logic [15:0] exp);
    int lat;
    start(v);
    check({name, " busy"}, busy, 1);
    wait_vld(0, '0, lat);
    check({name, " latency"}, lat, LAT);
    check({name, " y"}, y, exp);
    @(negedge clk);
    check({name, " pulse width"}, y_vld, 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (y_vld) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    vec_t vecs[12];
    int   lat;
    int   s0;
    int   n_rand;
    logic [31:0] cur;

    vecs[0]  = '{32'd0,          16'd0};
    vecs[1]  = '{32'd16,         16'd4};
    vecs[2]  = '{32'd15,         16'd3};
    vecs[3]  = '{32'd1,          16'd1};
    vecs[4]  = '{32'hFFFF_FFFF,  16'hFFFF};
    vecs[5]  = '{32'd2,          16'd1};
    vecs[6]  = '{32'd3,          16'd1};
    vecs[7]  = '{32'd4,          16'd2};
    vecs[8]  = '{32'd99,         16'd9};
    vecs[9]  = '{32'd1_000_000,  16'd1000};
    vecs[10] = '{32'hFFFE_0001,  16'hFFFF};
    vecs[11] = '{32'hFFFE_0000,  16'hFFFE};

    repeat (3) @(negedge clk);
    check("reset y_vld", y_vld, 0);
    check("reset y", y, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].y);

    // Back-to-back: second operand issued in the first result's y_vld cycle.
    start(32'd100);
    wait_vld(0, '0, lat);
    check("b2b first latency", lat, LAT);
    check("b2b first y", y, 10);
    start_now(32'd49);
    check("b2b accepted in done", busy, 1);
    check("b2b y held while busy", y, 10);
    wait_vld(0, '0, lat);
    check("b2b second latency", lat, LAT);
    check("b2b second y", y, 7);
    @(negedge clk);

    // x_vld while busy is ignored.
    start(32'd81);
    wait_vld(5, 32'd4, lat);
    check("busy pulse latency", lat, LAT);
    check("busy pulse y", y, 9);
    quiet("busy pulse no extra strobe", 24);

    // Reset mid-operation aborts silently and clears y.
    start(32'd144);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort y_vld", y_vld, 0);
    check("abort y", y, 0);
    check("abort busy", busy, 0);
    quiet("abort no strobe", 24);
    run_one("after abort", 32'd25, 16'd5);

    // Simultaneous rst and x_vld: nothing captured.
    @(negedge clk);
    rst   = 1'b1;
    x_vld = 1'b1;
    x     = 32'd9;
    @(negedge clk);
    rst   = 1'b0;
    x_vld = 1'b0;
    check("rst+x_vld busy", busy, 0);
    quiet("rst+x_vld no strobe", 24);

    // Random operands with random gaps (0 = back-to-back) and ignored pulses.
    n_rand = 2500;
    #1 s0 = strobes;
    @(negedge clk);
    cur = $urandom();
    start_now(cur);
    for (int i = 0; i < n_rand; i++) begin
      int pa;
      int g;
      pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
      wait_vld(pa, $urandom(), lat);
      check($sformatf("rand%0d latency", i), lat, LAT);
      check($sformatf("rand%0d y x=%0h", i, cur), y, ref_sqrt(cur));
      if (lat < 0) break;
      if (i < n_rand - 1) begin
        g = $urandom_range(0, 3);
        repeat (g) @(negedge clk);
        case ($urandom_range(0, 3))
          0:       cur = $urandom_range(0, 1023);
          1:       cur = 32'hFFFF_FFFF - $urandom_range(0, 255);
          default: cur = $urandom();
        endcase
        start_now(cur);
      end
    end
    repeat (3) @(negedge clk);
    #1 check("strobe count", strobes - s0, n_rand);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
